// File: rtl/msi_int_queue_bfm_if.sv
// MSI ingress and interrupt-delivery signals between the MSI detector, the queue and the sequencer.
interface msi_int_queue_bfm_if #(
    parameter int unsigned VEC_WD = 5
) ();
    logic              msi_detected;
    logic [31:0]       msi_data;
    logic              int_vld;
    logic              int_rdy;
    logic [VEC_WD-1:0] int_vec;
    logic [31:0]       int_raw;

    modport master (
        output msi_detected, msi_data, int_rdy,
        input  int_vld, int_vec, int_raw
    );

    modport slave (
        input  msi_detected, msi_data, int_rdy,
        output int_vld, int_vec, int_raw
    );
endinterface

// File: rtl/msi_int_queue_bfm.sv
// FWFT queue of detected MSIs with pending bitmap, drop/total statistics and an optional
// vector-order check enabled by defining MSI_INT_SEQ_CHECK_EN.
module msi_int_queue_bfm #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned VEC_WD = 5,
    parameter int unsigned CNT_WD = 16
) (
    input  logic                         core_clk,
    input  logic                         core_rst_n,
    msi_int_queue_bfm_if.slave           bus,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt,
    output logic [(2**VEC_WD)-1:0]       pend_vec,
    input  logic [(2**VEC_WD)-1:0]       pend_clr,
    output logic                         ovf,
    input  logic                         ovf_clr,
    output logic [CNT_WD-1:0]            ovf_cnt,
    output logic [CNT_WD-1:0]            msi_total,
    output logic                         seq_err
);
    localparam int unsigned PTR_WD = $clog2(DEPTH);
    localparam int unsigned CW     = $clog2(DEPTH+1);
    localparam int unsigned NV     = 2**VEC_WD;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

    state_e              state_q, state_d;
    logic [31:0]         mem_q [DEPTH];
    logic [PTR_WD-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WD-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NV-1:0]       pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic [CNT_WD-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic [CNT_WD-1:0]   total_q, total_d;
    logic                push, pop, drop, full;
    logic [VEC_WD-1:0]   in_vec;

    assign in_vec = bus.msi_data[VEC_WD-1:0];

    always_comb begin
        full      = (state_q == StFull);
        pop       = (cnt_q != '0) & bus.int_rdy;
        push      = bus.msi_detected & (~full | pop);
        drop      = bus.msi_detected & full & ~pop;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_WD'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_WD'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);

        if (cnt_d == '0)            state_d = StEmpty;
        else if (cnt_d == DEPTH_CNT) state_d = StFull;
        else                        state_d = StPartial;

        // Set wins over a same-cycle clear for both the pending bits and ovf.
        pend_d = pend_q & ~pend_clr;
        if (bus.msi_detected) pend_d = pend_d | (NV'(1) << in_vec);
        ovf_d = ovf_clr ? 1'b0 : ovf_q;
        if (drop) ovf_d = 1'b1;
        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_WD'(1);
        total_d = bus.msi_detected ? total_q + CNT_WD'(1) : total_q;
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            state_q   <= StEmpty;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
            total_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
            total_q   <= total_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge core_clk) begin
        if (core_rst_n && push) mem_q[wr_ptr_q] <= bus.msi_data;
    end

`ifdef MSI_INT_SEQ_CHECK_EN
    logic [VEC_WD-1:0] exp_vec_q, exp_vec_d;
    logic              seq_err_q, seq_err_d;

    always_comb begin
        exp_vec_d = exp_vec_q;
        seq_err_d = seq_err_q;
        if (push) begin
            exp_vec_d = in_vec + VEC_WD'(1);
            if (in_vec != exp_vec_q) seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            exp_vec_q <= '0;
            seq_err_q <= 1'b0;
        end else begin
            exp_vec_q <= exp_vec_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

    assign bus.int_vld = (cnt_q != '0);
    assign bus.int_raw = bus.int_vld ? mem_q[rd_ptr_q] : 32'h0;
    assign bus.int_vec = bus.int_raw[VEC_WD-1:0];
    assign fifo_cnt    = cnt_q;
    assign pend_vec    = pend_q;
    assign ovf         = ovf_q;
    assign ovf_cnt     = ovf_cnt_q;
    assign msi_total   = total_q;
endmodule

// File: tb/tb_msi_int_queue_bfm.sv
// Directed bench for msi_int_queue_bfm: reference model plus a scoreboard of expected payloads.
module tb_msi_int_queue_bfm;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned VEC_WD = 5;
    localparam int unsigned CNT_WD = 16;
    localparam int unsigned NV     = 2**VEC_WD;

    logic                       core_clk = 1'b0;
    logic                       core_rst_n;
    logic [$clog2(DEPTH+1)-1:0] fifo_cnt;
    logic [NV-1:0]              pend_vec;
    logic [NV-1:0]              pend_clr;
    logic                       ovf;
    logic                       ovf_clr;
    logic [CNT_WD-1:0]          ovf_cnt;
    logic [CNT_WD-1:0]          msi_total;
    logic                       seq_err;

    msi_int_queue_bfm_if #(.VEC_WD(VEC_WD)) bus ();

    msi_int_queue_bfm #(.DEPTH(DEPTH), .VEC_WD(VEC_WD), .CNT_WD(CNT_WD)) dut (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .bus        (bus.slave),
        .fifo_cnt   (fifo_cnt),
        .pend_vec   (pend_vec),
        .pend_clr   (pend_clr),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .ovf_cnt    (ovf_cnt),
        .msi_total  (msi_total),
        .seq_err    (seq_err)
    );

    always #5 core_clk = ~core_clk;

    int checks = 0;
    int errors = 0;

    logic [31:0]       sb[$];
    logic [NV-1:0]     m_pend;
    logic              m_ovf;
    logic [CNT_WD-1:0] m_ovf_cnt;
    logic [CNT_WD-1:0] m_total;
    logic [VEC_WD-1:0] m_exp_vec;
    logic              m_seq_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs in force, comparing popped heads.
    task automatic tick();
        logic              pop_m, push_m, drop_m;
        logic [31:0]       exp_raw;
        logic [VEC_WD-1:0] vec;
        vec    = bus.msi_data[VEC_WD-1:0];
        pop_m  = (sb.size() != 0) && bus.int_rdy;
        push_m = bus.msi_detected && ((sb.size() != DEPTH) || pop_m);
        drop_m = bus.msi_detected && (sb.size() == DEPTH) && !pop_m;
        if (!core_rst_n) begin
            sb.delete();
            m_pend = '0; m_ovf = 1'b0; m_ovf_cnt = '0; m_total = '0;
            m_exp_vec = '0; m_seq_err = 1'b0;
        end else begin
            if (pop_m) begin
                exp_raw = sb.pop_front();
                chk("pop_raw", 64'(bus.int_raw), 64'(exp_raw));
                chk("pop_vec", 64'(bus.int_vec), 64'(exp_raw[VEC_WD-1:0]));
            end
            if (push_m) begin
                sb.push_back(bus.msi_data);
`ifdef MSI_INT_SEQ_CHECK_EN
                if (vec != m_exp_vec) m_seq_err = 1'b1;
                m_exp_vec = vec + VEC_WD'(1);
`endif
            end
            m_pend = m_pend & ~pend_clr;
            if (bus.msi_detected) begin
                m_pend[vec] = 1'b1;
                m_total = m_total + CNT_WD'(1);
            end
            if (ovf_clr) m_ovf = 1'b0;
            if (drop_m) begin
                m_ovf = 1'b1;
                if (m_ovf_cnt != '1) m_ovf_cnt = m_ovf_cnt + CNT_WD'(1);
            end
        end
        @(posedge core_clk);
        #1;
        chk("fifo_cnt", 64'(fifo_cnt), 64'(sb.size()));
        chk("int_vld", 64'(bus.int_vld), 64'(sb.size() != 0));
        chk("pend_vec", 64'(pend_vec), 64'(m_pend));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf_cnt));
        chk("msi_total", 64'(msi_total), 64'(m_total));
        chk("seq_err", 64'(seq_err), 64'(m_seq_err));
        if (sb.size() != 0) chk("head_raw", 64'(bus.int_raw), 64'(sb[0]));
    endtask

    task automatic idle();
        bus.msi_detected = 1'b0;
        bus.msi_data     = 32'h0;
        bus.int_rdy      = 1'b0;
        pend_clr         = '0;
        ovf_clr          = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        core_rst_n = 1'b0;
        tick();
        core_rst_n = 1'b1;
    endtask

    task automatic msi(input logic [31:0] data, input logic rdy);
        bus.msi_detected = 1'b1;
        bus.msi_data     = data;
        bus.int_rdy      = rdy;
        tick();
        bus.msi_detected = 1'b0;
        bus.int_rdy      = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.int_rdy = 1'b1;
        for (int i = 0; i < n; i++) tick();
        bus.int_rdy = 1'b0;
    endtask

    initial begin
        idle();
        core_rst_n = 1'b0;
        m_pend = '0; m_ovf = 1'b0; m_ovf_cnt = '0; m_total = '0;
        m_exp_vec = '0; m_seq_err = 1'b0;
        @(posedge core_clk);
        #1;

        // T1: reset held for two clocks with an MSI pulse present.
        bus.msi_detected = 1'b1;
        bus.msi_data     = 32'h5;
        tick();
        tick();
        chk("t1_vld", 64'(bus.int_vld), 64'd0);
        chk("t1_raw", 64'(bus.int_raw), 64'd0);
        chk("t1_cnt", 64'(fifo_cnt), 64'd0);
        chk("t1_total", 64'(msi_total), 64'd0);
        chk("t1_pend", 64'(pend_vec), 64'd0);
        core_rst_n = 1'b1;
        idle();
        tick();

        // T2: one-cycle latency and FIFO order.
        msi(32'h0, 1'b0);
        chk("t2_vld_n1", 64'(bus.int_vld), 64'd1);
        chk("t2_raw_n1", 64'(bus.int_raw), 64'h0);
        msi(32'h1, 1'b0);
        msi(32'h2, 1'b0);
        chk("t2_cnt3", 64'(fifo_cnt), 64'd3);
        drain(3);
        chk("t2_vld_end", 64'(bus.int_vld), 64'd0);
        // Ready while empty must not move anything.
        drain(2);
        chk("t2_empty_rdy", 64'(fifo_cnt), 64'd0);

        // T3: overflow with sticky flag and saturating counter.
        do_reset();
        for (int i = 0; i < 10; i++) msi(32'h100 + 32'(i), 1'b0);
        chk("t3_cnt", 64'(fifo_cnt), 64'd8);
        chk("t3_ovf", 64'(ovf), 64'd1);
        chk("t3_ovf_cnt", 64'(ovf_cnt), 64'd2);
        chk("t3_total", 64'(msi_total), 64'd10);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 64'(ovf), 64'd0);
        chk("t3_ovf_cnt_kept", 64'(ovf_cnt), 64'd2);
        // Drop and ovf_clr together: set wins.
        ovf_clr = 1'b1;
        msi(32'h1ff, 1'b0);
        ovf_clr = 1'b0;
        chk("t3_set_wins", 64'(ovf), 64'd1);
        chk("t3_ovf_cnt3", 64'(ovf_cnt), 64'd3);

        // T4: push accepted on full when popping, then wrap with 20 push/pop pairs.
        msi(32'h200, 1'b1);
        chk("t4_cnt_full", 64'(fifo_cnt), 64'd8);
        chk("t4_no_drop", 64'(ovf_cnt), 64'd3);
        for (int i = 0; i < 20; i++) msi(32'h300 + 32'(i), 1'b1);
        chk("t4_cnt_wrap", 64'(fifo_cnt), 64'd8);
        drain(8);
        chk("t4_drained", 64'(bus.int_vld), 64'd0);

        // T5: pending bitmap, upper payload bits carried only in int_raw.
        do_reset();
        msi(32'h23, 1'b0);
        chk("t5_pend3", 64'(pend_vec[3]), 64'd1);
        chk("t5_vec", 64'(bus.int_vec), 64'd3);
        chk("t5_raw", 64'(bus.int_raw), 64'h23);
        pend_clr = NV'(1) << 3;
        msi(32'hdead_be43, 1'b0);
        chk("t5_set_wins", 64'(pend_vec[3]), 64'd1);
        tick();
        pend_clr = '0;
        chk("t5_cleared", 64'(pend_vec[3]), 64'd0);
        drain(2);

        // T6: vector-order check on an out-of-order stream.
        do_reset();
        msi(32'h0, 1'b1);
        msi(32'h1, 1'b1);
        chk("t6_no_err", 64'(seq_err), 64'd0);
        msi(32'h3, 1'b1);
`ifdef MSI_INT_SEQ_CHECK_EN
        chk("t6_err_v3", 64'(seq_err), 64'd1);
`else
        chk("t6_err_v3", 64'(seq_err), 64'd0);
`endif
        msi(32'h4, 1'b1);
`ifdef MSI_INT_SEQ_CHECK_EN
        chk("t6_err_sticky", 64'(seq_err), 64'd1);
`else
        chk("t6_err_sticky", 64'(seq_err), 64'd0);
`endif
        drain(2);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
